// File: rtl/frame_streamer.sv
// Raster frame source/sink: fetch pixels from sync frame memory and stream them with x/y/sync; write returned pixels back in raster order.
// Start-to-first-valid is 2 cycles. out_ready low holds the 2-entry buffer and pauses fetch; en low freezes everything except in-flight read capture.
module frame_streamer #(
  parameter int PIXEL_SIZE = 24,
  parameter int ADDR_W     = 19,
  parameter int DIM_W      = 12,
  parameter int H_BLANK    = 4,
  parameter int V_BLANK    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  start,
  input  logic                  loop,
  input  logic [DIM_W-1:0]      width,
  input  logic [DIM_W-1:0]      height,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [PIXEL_SIZE-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PIXEL_SIZE-1:0] out_pixel,
  output logic [DIM_W-1:0]      x,
  output logic [DIM_W-1:0]      y,
  output logic                  hsync,
  output logic                  vsync,
  input  logic                  in_valid,
  input  logic [PIXEL_SIZE-1:0] in_pixel,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [PIXEL_SIZE-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           frame
);
  localparam int BT_W = 16;
  localparam logic [BT_W-1:0] H_LOAD = BT_W'((H_BLANK > 0) ? H_BLANK - 1 : 0);
  localparam logic [BT_W-1:0] V_LOAD = BT_W'((V_BLANK > 0) ? V_BLANK - 1 : 0);

  typedef enum logic [2:0] {IDLE, ACTIVE, HBLANK, VBLANK, DRAIN} state_t;

  typedef struct packed {
    logic [DIM_W-1:0] x;
    logic [DIM_W-1:0] y;
    logic             hsync;
    logic             vsync;
  } meta_t;

  typedef struct packed {
    logic [PIXEL_SIZE-1:0] pixel;
    meta_t                 meta;
  } ent_t;

  state_t           state;
  logic [DIM_W-1:0] w_lat, h_lat, fx, fy, wcol, wrow;
  logic             loop_lat;
  logic [BT_W-1:0]  btimer;
  logic             rd_pend;
  meta_t            pend_meta;
  ent_t             fifo_mem [2];
  logic             wp, rp;
  logic [1:0]       cnt, cnt_after, occ;
  logic             xfer;
  ent_t             head;

  assign head      = fifo_mem[rp];
  assign out_valid = en && (cnt != 2'd0);
  assign xfer      = out_valid && out_ready;
  // Occupancy counts the slot freed by this cycle's transfer so a row streams at one pixel per cycle.
  assign cnt_after = cnt - {1'b0, xfer};
  assign occ       = cnt_after + {1'b0, rd_pend};
  assign rd_en     = en && (state == ACTIVE) && (occ < 2'd2);

  assign out_pixel = head.pixel;
  assign x         = head.meta.x;
  assign y         = head.meta.y;
  assign hsync     = head.meta.hsync;
  assign vsync     = head.meta.vsync;
  assign busy      = (state != IDLE);

  assign wr_en     = in_valid && en;
  assign wr_data   = in_pixel;

  // Read data is captured whenever it returns, even with en low, so nothing in flight is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wp          <= 1'b0;
      rp          <= 1'b0;
      cnt         <= 2'd0;
      rd_pend     <= 1'b0;
      pend_meta   <= '0;
    end else begin
      rd_pend <= rd_en;
      if (rd_en)
        pend_meta <= '{x: fx, y: fy, hsync: (fx == '0), vsync: (fx == '0) && (fy == '0)};
      if (rd_pend) begin
        fifo_mem[wp] <= '{pixel: rd_data, meta: pend_meta};
        wp           <= ~wp;
      end
      if (xfer)
        rp <= ~rp;
      cnt <= occ;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      w_lat    <= '0;
      h_lat    <= '0;
      loop_lat <= 1'b0;
      fx       <= '0;
      fy       <= '0;
      rd_addr  <= '0;
      btimer   <= '0;
      done     <= 1'b0;
      frame    <= '0;
    end else begin
      done <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            if (start && (width != '0) && (height != '0)) begin
              w_lat    <= width;
              h_lat    <= height;
              loop_lat <= loop;
              fx       <= '0;
              fy       <= '0;
              rd_addr  <= '0;
              state    <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (rd_en) begin
              rd_addr <= rd_addr + 1'b1;
              if (fx == w_lat - 1'b1) begin
                fx <= '0;
                if (fy == h_lat - 1'b1) begin
                  state <= DRAIN;
                end else begin
                  fy <= fy + 1'b1;
                  if (H_BLANK > 0) begin
                    btimer <= H_LOAD;
                    state  <= HBLANK;
                  end
                end
              end else begin
                fx <= fx + 1'b1;
              end
            end
          end
          HBLANK, VBLANK: begin
            if (btimer == '0) state <= ACTIVE;
            else              btimer <= btimer - 1'b1;
          end
          DRAIN: begin
            // Exit on the edge of the last transfer so done/busy land in the following cycle.
            if ((cnt_after == 2'd0) && !rd_pend) begin
              frame   <= frame + 32'd1;
              fx      <= '0;
              fy      <= '0;
              rd_addr <= '0;
              if (loop_lat && loop) begin
                if (V_BLANK > 0) begin
                  btimer <= V_LOAD;
                  state  <= VBLANK;
                end else begin
                  state <= ACTIVE;
                end
              end else begin
                loop_lat <= 1'b0;
                done     <= 1'b1;
                state    <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Write-back walks the latched frame geometry, wrapping after the last pixel without a multiply.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr <= '0;
      wcol    <= '0;
      wrow    <= '0;
    end else if (wr_en) begin
      if (wcol == w_lat - 1'b1) begin
        wcol <= '0;
        if (wrow == h_lat - 1'b1) begin
          wrow    <= '0;
          wr_addr <= '0;
        end else begin
          wrow    <= wrow + 1'b1;
          wr_addr <= wr_addr + 1'b1;
        end
      end else begin
        wcol    <= wcol + 1'b1;
        wr_addr <= wr_addr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_frame_streamer.sv
// Self-checking bench for frame_streamer: raster reference model, random memory contents and random backpressure.
module tb_frame_streamer;
  localparam int PW = 24;
  localparam int AW = 19;
  localparam int DW = 12;
  localparam int HB = 2;
  localparam int VB = 3;

  logic          clk = 1'b0;
  logic          reset, en, start, loop, rd_en, out_valid, out_ready, hsync, vsync;
  logic          in_valid, wr_en, busy, done;
  logic [DW-1:0] width, height, x, y;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [PW-1:0] rd_data, out_pixel, in_pixel, wr_data;
  logic [31:0]   frame;

  int vectors = 0;
  int miscompares = 0;
  bit rdy_mode = 1'b0;

  frame_streamer #(.PIXEL_SIZE(PW), .ADDR_W(AW), .DIM_W(DW), .H_BLANK(HB), .V_BLANK(VB)) dut (
    .clk(clk), .reset(reset), .en(en), .start(start), .loop(loop),
    .width(width), .height(height), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel), .x(x), .y(y),
    .hsync(hsync), .vsync(vsync), .in_valid(in_valid), .in_pixel(in_pixel),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .frame(frame)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port frame memory, read data one cycle after rd_en.
  logic [PW-1:0] mem [256];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[7:0]];

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  typedef struct {
    logic [PW-1:0] pix;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic          hs;
    logic          vs;
    int            cyc;
  } xfer_t;

  xfer_t got_q[$];
  xfer_t exp_q[$];
  int    rd_q[$];
  int    done_cnt, done_cyc, stall_viol;
  logic  busy_at_done, hold;
  logic [PW+2*DW+1:0] held;

  always @(negedge clk) begin
    if (reset) begin
      rd_q.delete();
      got_q.delete();
      done_cnt   <= 0;
      done_cyc   <= 0;
      stall_viol <= 0;
      hold       <= 1'b0;
    end else begin
      if (rd_en) rd_q.push_back(cyc);
      if (out_valid && out_ready && en) got_q.push_back('{out_pixel, x, y, hsync, vsync, cyc});
      if (done) begin
        done_cnt     <= done_cnt + 1;
        done_cyc     <= cyc;
        busy_at_done <= busy;
      end
      if (en) begin
        if (hold && (!out_valid || {out_pixel, x, y, hsync, vsync} !== held)) stall_viol <= stall_viol + 1;
        hold <= out_valid && !out_ready;
        held <= {out_pixel, x, y, hsync, vsync};
      end
    end
  end

  // Reference: frames are streamed in plain raster order, pixel = mem[row*width+col].
  task automatic build_exp(input int w, input int h, input int nf);
    exp_q.delete();
    for (int f = 0; f < nf; f++)
      for (int r = 0; r < h; r++)
        for (int c = 0; c < w; c++)
          exp_q.push_back('{pix: mem[r*w+c], x: DW'(c), y: DW'(r), hs: (c == 0), vs: (c == 0 && r == 0), cyc: 0});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1; en = 1'b1; start = 1'b0; loop = 1'b0; in_valid = 1'b0; in_pixel = '0; rdy_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic start_frame(input logic [DW-1:0] w, input logic [DW-1:0] h, input bit lp, output int sc);
    @(posedge clk);
    #1;
    width = w; height = h; loop = lp; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sc = cyc;
  endtask

  task automatic wait_idle(input int maxc, output bit to);
    to = 1'b1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        to = 1'b0;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    int sc;
    do_reset();
    @(negedge clk);
    vectors++;
    if ({busy, out_valid, rd_en, done, hsync, vsync, wr_en} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 0000000", {busy, out_valid, rd_en, done, hsync, vsync, wr_en});
    end
    vectors++;
    if (frame !== 32'd0) begin miscompares++; $display("FAIL reset_frame got %0d want 0", frame); end
    vectors++;
    if ({x, y, out_pixel, rd_addr, wr_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_fields got x=%0d y=%0d pix=%h ra=%0d wa=%0d want all 0", x, y, out_pixel, rd_addr, wr_addr);
    end
    start_frame(0, 3, 1'b0, sc);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if ({busy, rd_en} !== 2'b00) begin
        miscompares++;
        $display("FAIL zero_width_start cycle %0d got busy=%b rd_en=%b want 0 0", i, busy, rd_en);
      end
    end
  endtask

  task automatic test_basic();
    int sc;
    bit to;
    do_reset();
    for (int i = 0; i < 12; i++) mem[i] = PW'(i);
    build_exp(4, 3, 1);
    start_frame(4, 3, 1'b0, sc);
    wait_idle(400, to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL basic_timeout busy still 1 want 0"); end
    vectors++;
    if (got_q.size() !== 12) begin miscompares++; $display("FAIL basic_count got %0d want 12", got_q.size()); end
    for (int i = 0; i < 12 && i < got_q.size(); i++) begin
      vectors++;
      if ({got_q[i].pix, got_q[i].x, got_q[i].y, got_q[i].hs, got_q[i].vs} !==
          {exp_q[i].pix, exp_q[i].x, exp_q[i].y, exp_q[i].hs, exp_q[i].vs}) begin
        miscompares++;
        $display("FAIL basic_pix[%0d] got %h (%0d,%0d) hs=%b vs=%b want %h (%0d,%0d) hs=%b vs=%b", i,
                 got_q[i].pix, got_q[i].x, got_q[i].y, got_q[i].hs, got_q[i].vs,
                 exp_q[i].pix, exp_q[i].x, exp_q[i].y, exp_q[i].hs, exp_q[i].vs);
      end
    end
    vectors++;
    if (rd_q.size() !== 12) begin
      miscompares++;
      $display("FAIL basic_reads got %0d want 12", rd_q.size());
    end else begin
      vectors++;
      if (rd_q[0] - sc !== 0) begin miscompares++; $display("FAIL first_rd_latency got %0d want 0", rd_q[0] - sc); end
      for (int i = 1; i < 12; i++) begin
        vectors++;
        if (rd_q[i] - rd_q[i-1] !== ((i % 4 == 0) ? HB + 1 : 1)) begin
          miscompares++;
          $display("FAIL fetch_gap[%0d] got %0d want %0d", i, rd_q[i] - rd_q[i-1], (i % 4 == 0) ? HB + 1 : 1);
        end
      end
      for (int i = 0; i < 12 && i < got_q.size(); i++) begin
        vectors++;
        if (got_q[i].cyc - rd_q[i] !== 2) begin
          miscompares++;
          $display("FAIL rd_to_xfer[%0d] got %0d want 2", i, got_q[i].cyc - rd_q[i]);
        end
      end
    end
    if (got_q.size() > 0) begin
      vectors++;
      if (got_q[0].cyc - sc !== 2) begin miscompares++; $display("FAIL start_latency got %0d want 2", got_q[0].cyc - sc); end
      vectors++;
      if (done_cyc !== got_q[got_q.size()-1].cyc + 1) begin
        miscompares++;
        $display("FAIL done_timing got %0d want %0d", done_cyc, got_q[got_q.size()-1].cyc + 1);
      end
    end
    vectors++;
    if (done_cnt !== 1) begin miscompares++; $display("FAIL basic_done got %0d want 1", done_cnt); end
    vectors++;
    if (busy_at_done !== 1'b0) begin miscompares++; $display("FAIL busy_at_done got %b want 0", busy_at_done); end
    vectors++;
    if (frame !== 32'd1) begin miscompares++; $display("FAIL basic_frame got %0d want 1", frame); end
  endtask

  task automatic test_stall();
    int sc;
    bit to;
    do_reset();
    for (int i = 0; i < 12; i++) mem[i] = PW'($urandom);
    build_exp(4, 3, 1);
    rdy_mode = 1'b1;
    start_frame(4, 3, 1'b0, sc);
    wait_idle(1000, to);
    rdy_mode = 1'b0;
    vectors++;
    if (to) begin miscompares++; $display("FAIL stall_timeout busy still 1 want 0"); end
    vectors++;
    if (got_q.size() !== 12) begin miscompares++; $display("FAIL stall_count got %0d want 12", got_q.size()); end
    for (int i = 0; i < 12 && i < got_q.size(); i++) begin
      vectors++;
      if ({got_q[i].pix, got_q[i].x, got_q[i].y, got_q[i].hs, got_q[i].vs} !==
          {exp_q[i].pix, exp_q[i].x, exp_q[i].y, exp_q[i].hs, exp_q[i].vs}) begin
        miscompares++;
        $display("FAIL stall_pix[%0d] got %h (%0d,%0d) want %h (%0d,%0d)", i,
                 got_q[i].pix, got_q[i].x, got_q[i].y, exp_q[i].pix, exp_q[i].x, exp_q[i].y);
      end
    end
    vectors++;
    if (stall_viol !== 0) begin miscompares++; $display("FAIL stall_stability got %0d changes want 0", stall_viol); end
    vectors++;
    if (done_cnt !== 1) begin miscompares++; $display("FAIL stall_done got %0d want 1", done_cnt); end
    vectors++;
    if (frame !== 32'd1) begin miscompares++; $display("FAIL stall_frame got %0d want 1", frame); end
  endtask

  task automatic test_loop();
    int sc;
    bit to;
    do_reset();
    for (int i = 0; i < 4; i++) mem[i] = PW'($urandom);
    build_exp(2, 2, 3);
    start_frame(2, 2, 1'b1, sc);
    to = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (frame === 32'd2) begin
        to = 1'b0;
        break;
      end
    end
    vectors++;
    if (to) begin miscompares++; $display("FAIL loop_frame2_timeout got frame=%0d want 2", frame); end
    @(posedge clk);
    #1;
    loop = 1'b0;
    wait_idle(1000, to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL loop_idle_timeout busy still 1 want 0"); end
    vectors++;
    if (got_q.size() !== 12) begin miscompares++; $display("FAIL loop_count got %0d want 12", got_q.size()); end
    for (int i = 0; i < 12 && i < got_q.size(); i++) begin
      vectors++;
      if ({got_q[i].pix, got_q[i].x, got_q[i].y, got_q[i].hs, got_q[i].vs} !==
          {exp_q[i].pix, exp_q[i].x, exp_q[i].y, exp_q[i].hs, exp_q[i].vs}) begin
        miscompares++;
        $display("FAIL loop_pix[%0d] got %h (%0d,%0d) vs=%b want %h (%0d,%0d) vs=%b", i,
                 got_q[i].pix, got_q[i].x, got_q[i].y, got_q[i].vs, exp_q[i].pix, exp_q[i].x, exp_q[i].y, exp_q[i].vs);
      end
    end
    if (got_q.size() >= 12 && rd_q.size() >= 12) begin
      for (int k = 1; k < 3; k++) begin
        vectors++;
        if (rd_q[4*k] - got_q[4*k-1].cyc - 1 !== VB) begin
          miscompares++;
          $display("FAIL vblank_gap[%0d] got %0d want %0d", k, rd_q[4*k] - got_q[4*k-1].cyc - 1, VB);
        end
      end
    end
    vectors++;
    if (frame !== 32'd3) begin miscompares++; $display("FAIL loop_frame got %0d want 3", frame); end
    vectors++;
    if (done_cnt !== 1) begin miscompares++; $display("FAIL loop_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_en_gap();
    int sc;
    bit to;
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = PW'($urandom);
    build_exp(8, 2, 1);
    start_frame(8, 2, 1'b0, sc);
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (got_q.size() >= 3) begin
        to = 1'b0;
        break;
      end
    end
    vectors++;
    if (to) begin miscompares++; $display("FAIL en_gap_wait got %0d transfers want 3", got_q.size()); end
    @(posedge clk);
    #1;
    en = 1'b0; in_valid = 1'b1; in_pixel = PW'($urandom);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if ({rd_en, out_valid, wr_en, busy} !== 4'b0001) begin
        miscompares++;
        $display("FAIL en_low[%0d] got rd=%b ov=%b wr=%b busy=%b want 0 0 0 1", i, rd_en, out_valid, wr_en, busy);
      end
    end
    @(posedge clk);
    #1;
    en = 1'b1; in_valid = 1'b0;
    wait_idle(400, to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL en_gap_timeout busy still 1 want 0"); end
    vectors++;
    if (got_q.size() !== 16) begin miscompares++; $display("FAIL en_gap_count got %0d want 16", got_q.size()); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      vectors++;
      if ({got_q[i].pix, got_q[i].x, got_q[i].y, got_q[i].hs, got_q[i].vs} !==
          {exp_q[i].pix, exp_q[i].x, exp_q[i].y, exp_q[i].hs, exp_q[i].vs}) begin
        miscompares++;
        $display("FAIL en_gap_pix[%0d] got %h (%0d,%0d) want %h (%0d,%0d)", i,
                 got_q[i].pix, got_q[i].x, got_q[i].y, exp_q[i].pix, exp_q[i].x, exp_q[i].y);
      end
    end
    vectors++;
    if (wr_addr !== '0) begin miscompares++; $display("FAIL en_gap_wr_addr got %0d want 0", wr_addr); end
    vectors++;
    if (done_cnt !== 1) begin miscompares++; $display("FAIL en_gap_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_writeback();
    int sc;
    bit to;
    logic [PW-1:0] d;
    do_reset();
    start_frame(4, 3, 1'b0, sc);
    wait_idle(400, to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL wb_timeout busy still 1 want 0"); end
    for (int k = 0; k < 13; k++) begin
      @(posedge clk);
      #1;
      d = PW'($urandom);
      in_valid = 1'b1; in_pixel = d;
      @(negedge clk);
      vectors++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, AW'(k % 12), d}) begin
        miscompares++;
        $display("FAIL write[%0d] got en=%b addr=%0d data=%h want en=1 addr=%0d data=%h", k, wr_en, wr_addr, wr_data, k % 12, d);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  task automatic test_reset_midframe();
    int sc;
    bit to;
    do_reset();
    for (int i = 0; i < 12; i++) mem[i] = PW'($urandom);
    start_frame(4, 3, 1'b0, sc);
    wait_idle(400, to);
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_pixel = PW'($urandom);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start_frame(4, 3, 1'b0, sc);
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if ({busy, frame, wr_addr} !== {1'b1, 32'd1, AW'(1)}) begin
      miscompares++;
      $display("FAIL pre_reset got busy=%b frame=%0d wa=%0d want 1 1 1", busy, frame, wr_addr);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({busy, out_valid, rd_en, done, hsync, vsync} !== 6'b0) begin
      miscompares++;
      $display("FAIL midframe_reset_flags got %b want 000000", {busy, out_valid, rd_en, done, hsync, vsync});
    end
    vectors++;
    if ({frame, wr_addr, rd_addr} !== '0) begin
      miscompares++;
      $display("FAIL midframe_reset_counters got frame=%0d wa=%0d ra=%0d want 0 0 0", frame, wr_addr, rd_addr);
    end
    vectors++;
    if ({x, y, out_pixel} !== '0) begin
      miscompares++;
      $display("FAIL midframe_reset_head got x=%0d y=%0d pix=%h want 0 0 0", x, y, out_pixel);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; en = 1'b1; start = 1'b0; loop = 1'b0;
    width = '0; height = '0; in_valid = 1'b0; in_pixel = '0;
    test_reset();
    test_basic();
    test_stall();
    test_loop();
    test_en_gap();
    test_writeback();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
